// File: rtl/overture_debug_ctrl.sv
// Debug controller for a small CPU: host commands drive run/halt/step/reset,
// with a single PC breakpoint and a saturating run-cycle counter.
//
// state       | meaning
// RESETTING   | cpu_reset held high while rst_cnt counts down
// HALTED      | CPU stopped, accepting all commands
// RUNNING     | CPU free-running until HALT or breakpoint match
// STEPPING    | CPU runs exactly step_cnt cycles, commands blocked
module overture_debug_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic [7:0]  pc,
  input  logic [7:0]  instr_debug,
  output logic        cpu_run,
  output logic        cpu_reset,
  output logic        halted,
  output logic        bp_hit,
  output logic [7:0]  last_instr,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    S_RESETTING = 2'd0,
    S_HALTED    = 2'd1,
    S_RUNNING   = 2'd2,
    S_STEPPING  = 2'd3
  } state_t;

  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_CPU_RESET = 3'd6;
  localparam logic [2:0] OP_CLR_COUNT = 3'd7;

  state_t      state, state_nxt;
  logic [1:0]  rst_cnt, rst_cnt_nxt;
  logic [7:0]  step_cnt, step_cnt_nxt;
  logic        bp_en, bp_en_nxt;
  logic [7:0]  bp_addr, bp_addr_nxt;
  logic        skip_flag;
  logic        cmd_acc;
  logic        bp_match;

  assign cmd_ready = (state == S_HALTED) || (state == S_RUNNING);
  assign halted    = (state == S_HALTED);
  assign cpu_reset = (state == S_RESETTING);
  assign cmd_acc   = cmd_valid && cmd_ready;
  // skip_flag lets a resume from the breakpoint address execute that instruction
  assign bp_match  = (state == S_RUNNING) && bp_en && (pc == bp_addr) && !skip_flag;

  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    step_cnt_nxt = step_cnt;
    bp_en_nxt    = bp_en;
    bp_addr_nxt  = bp_addr;
    cpu_run      = 1'b0;
    case (state)
      S_RESETTING: begin
        rst_cnt_nxt = rst_cnt - 2'd1;
        if (rst_cnt <= 2'd1) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN: state_nxt = S_RUNNING;
            OP_STEP: begin
              if (cmd_arg != 8'd0) begin
                step_cnt_nxt = cmd_arg;
                state_nxt    = S_STEPPING;
              end
            end
            OP_CPU_RESET: begin
              rst_cnt_nxt = 2'd2;
              state_nxt   = S_RESETTING;
            end
            default: ;
          endcase
        end
      end
      S_RUNNING: begin
        cpu_run = !bp_match;
        if (bp_match || (cmd_acc && cmd_op == OP_HALT)) state_nxt = S_HALTED;
      end
      S_STEPPING: begin
        cpu_run      = 1'b1;
        step_cnt_nxt = step_cnt - 8'd1;
        if (step_cnt <= 8'd1) state_nxt = S_HALTED;
      end
      default: state_nxt = S_RESETTING;
    endcase
    if (cmd_acc && cmd_op == OP_SET_BP) begin
      bp_addr_nxt = cmd_arg;
      bp_en_nxt   = 1'b1;
    end
    if (cmd_acc && cmd_op == OP_CLR_BP) bp_en_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RESETTING;
      rst_cnt     <= 2'd2;
      step_cnt    <= 8'd0;
      bp_en       <= 1'b0;
      bp_addr     <= 8'd0;
      skip_flag   <= 1'b0;
      bp_hit      <= 1'b0;
      last_instr  <= 8'd0;
      cycle_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      rst_cnt   <= rst_cnt_nxt;
      step_cnt  <= step_cnt_nxt;
      bp_en     <= bp_en_nxt;
      bp_addr   <= bp_addr_nxt;
      skip_flag <= (state_nxt == S_RUNNING) && (state != S_RUNNING);
      bp_hit    <= bp_match;
      if ((state_nxt == S_HALTED) && ((state == S_RUNNING) || (state == S_STEPPING)))
        last_instr <= instr_debug;
      // clear wins over a concurrent increment
      if (cmd_acc && cmd_op == OP_CLR_COUNT)
        cycle_count <= 16'd0;
      else if (cpu_run && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_overture_debug_ctrl.sv
// Bench for overture_debug_ctrl: a behavioural model with a simple CPU
// (pc counts while running) plus directed scenarios with literal expectations.
module tb_overture_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_arg = 8'd0;
  logic [7:0]  tb_pc;
  logic [7:0]  tb_instr;
  logic        cmd_ready, cpu_run, cpu_reset, halted, bp_hit;
  logic [7:0]  last_instr;
  logic [15:0] cycle_count;

  int total = 0;
  int bad = 0;

  assign tb_instr = {tb_pc[3:0], tb_pc[7:4]} ^ 8'h5A;

  always #5 clk = ~clk;

  overture_debug_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .pc(tb_pc), .instr_debug(tb_instr),
    .cpu_run(cpu_run), .cpu_reset(cpu_reset), .halted(halted), .bp_hit(bp_hit),
    .last_instr(last_instr), .cycle_count(cycle_count)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MD_RST = 0, MD_HALT = 1, MD_RUN = 2, MD_STEP = 3;
  int          m_mode, m_rst_left, m_steps_left;
  logic        m_bp_en, m_first, m_hit;
  logic [7:0]  m_bp_addr, m_last;
  logic [15:0] m_count;
  logic        e_stop, e_run, s_run, s_stop, s_acc;

  assign e_stop = (m_mode == MD_RUN) && m_bp_en && (tb_pc == m_bp_addr) && !m_first;
  assign e_run  = (m_mode == MD_STEP) || ((m_mode == MD_RUN) && !e_stop);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = MD_RST; m_rst_left = 2; m_steps_left = 0;
      m_bp_en = 1'b0; m_bp_addr = 8'd0; m_first = 1'b0; m_hit = 1'b0;
      m_last = 8'd0; m_count = 16'd0;
      tb_pc <= 8'd0;
    end else begin
      s_run  = e_run;
      s_stop = e_stop;
      s_acc  = cmd_valid && (m_mode == MD_HALT || m_mode == MD_RUN);
      if (m_mode == MD_RST) tb_pc <= 8'd0;
      else if (s_run) tb_pc <= tb_pc + 8'd1;
      m_hit = s_stop;
      if (s_acc && cmd_op == 3'd7) m_count = 16'd0;
      else if (s_run && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (s_acc && cmd_op == 3'd4) begin m_bp_addr = cmd_arg; m_bp_en = 1'b1; end
      if (s_acc && cmd_op == 3'd5) m_bp_en = 1'b0;
      case (m_mode)
        MD_RST: begin
          m_rst_left--;
          if (m_rst_left == 0) m_mode = MD_HALT;
        end
        MD_HALT: if (s_acc) begin
          if (cmd_op == 3'd1) begin m_mode = MD_RUN; m_first = 1'b1; end
          else if (cmd_op == 3'd3 && cmd_arg != 8'd0) begin m_mode = MD_STEP; m_steps_left = int'(cmd_arg); end
          else if (cmd_op == 3'd6) begin m_mode = MD_RST; m_rst_left = 2; end
        end
        MD_RUN: begin
          m_first = 1'b0;
          if (s_stop || (s_acc && cmd_op == 3'd2)) begin m_mode = MD_HALT; m_last = tb_instr; end
        end
        default: begin
          m_steps_left--;
          if (m_steps_left == 0) begin m_mode = MD_HALT; m_last = tb_instr; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("cpu_run",     int'(cpu_run),     int'(e_run));
    check("cpu_reset",   int'(cpu_reset),   int'(m_mode == MD_RST));
    check("halted",      int'(halted),      int'(m_mode == MD_HALT));
    check("cmd_ready",   int'(cmd_ready),   int'(m_mode == MD_HALT || m_mode == MD_RUN));
    check("bp_hit",      int'(bp_hit),      int'(m_hit));
    check("last_instr",  int'(last_instr),  int'(m_last));
    check("cycle_count", int'(cycle_count), int'(m_count));
  end

  // ---------------- stimulus ----------------
  task automatic drive_now(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
    @(negedge clk);
    drive_now(op, arg);
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    @(negedge clk);
    while (!halted && n < 400) begin @(negedge clk); n++; end
    if (!halted) check(name, 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int runs, rsts, rdys, n;
    logic [7:0] target;

    repeat (3) @(negedge clk);
    check("por_cpu_reset", int'(cpu_reset), 1);
    check("por_cpu_run", int'(cpu_run), 0);
    check("por_ready", int'(cmd_ready), 0);
    check("por_halted", int'(halted), 0);
    check("por_count", int'(cycle_count), 0);
    @(posedge clk); #1 reset = 1'b1;
    rsts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (halted) break;
      if (cpu_reset) rsts++;
    end
    check("por_reset_cycles", rsts, 2);
    check("por_halted_after", int'(halted), 1);
    check("por_ready_after", int'(cmd_ready), 1);

    // STEP 5
    send_cmd(3'd3, 8'd5);
    runs = 0; rdys = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
      if (cpu_run) runs++;
      if (cmd_ready) rdys++;
    end
    check("step5_runs", runs, 5);
    check("step5_ready", rdys, 0);
    check("step5_halted", int'(halted), 1);
    check("step5_count", int'(cycle_count), 5);

    // CPU_RESET
    send_cmd(3'd6, 8'd0);
    rsts = 0; rdys = 0;
    for (int i = 0; i < 10; i++) begin
      if (halted && i > 0) break;
      @(negedge clk);
      if (cpu_reset) rsts++;
      if (cmd_ready) rdys++;
    end
    check("cpurst_cycles", rsts, 2);
    check("cpurst_ready", rdys, 1);
    check("cpurst_count", int'(cycle_count), 5);

    // breakpoint at 0x04 from pc 0
    send_cmd(3'd4, 8'h04);
    send_cmd(3'd1, 8'd0);
    runs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (halted) break;
      if (cpu_run) runs++;
    end
    check("bp_runs", runs, 4);
    check("bp_hit_pulse", int'(bp_hit), 1);
    check("bp_last_instr", int'(last_instr), 8'h1A);
    @(negedge clk);
    check("bp_hit_clear", int'(bp_hit), 0);
    send_cmd(3'd1, 8'd0);
    repeat (3) @(negedge clk);
    check("resume_running", int'(halted), 0);
    check("resume_cpu_run", int'(cpu_run), 1);
    send_cmd(3'd2, 8'd0);
    @(negedge clk);
    check("halt_cmd", int'(halted), 1);

    // HALT on the same cycle as a breakpoint match
    target = tb_pc + 8'd3;
    send_cmd(3'd4, target);
    send_cmd(3'd1, 8'd0);
    n = 0;
    @(negedge clk);
    while (tb_pc != target && n < 50) begin @(negedge clk); n++; end
    check("coinc_run_off", int'(cpu_run), 0);
    drive_now(3'd2, 8'd0);
    @(negedge clk);
    check("coinc_halted", int'(halted), 1);
    check("coinc_bp_hit", int'(bp_hit), 1);
    @(negedge clk);
    check("coinc_bp_clear", int'(bp_hit), 0);

    // STEP 0 is a no-op; STEP 3 from the breakpoint pc ignores it and blocks RUN
    send_cmd(3'd3, 8'd0);
    @(negedge clk);
    check("step0_halted", int'(halted), 1);
    send_cmd(3'd3, 8'd3);
    send_cmd(3'd1, 8'd0);
    wait_halted("step3_timeout");
    repeat (2) @(negedge clk);
    check("step3_stays_halted", int'(halted), 1);

    // saturation and CLR_COUNT priority
    send_cmd(3'd5, 8'd0);
    send_cmd(3'd7, 8'd0);
    @(negedge clk);
    check("clr_halted", int'(cycle_count), 0);
    send_cmd(3'd1, 8'd0);
    n = 0;
    while (m_count != 16'hFFFE && n < 70000) begin @(negedge clk); n++; end
    check("sat_fffe", int'(cycle_count), 65534);
    repeat (3) @(negedge clk);
    check("sat_ffff", int'(cycle_count), 65535);
    send_cmd(3'd7, 8'd0);
    @(negedge clk);
    check("clr_priority", int'(cycle_count), 0);
    send_cmd(3'd2, 8'd0);
    wait_halted("sat_halt_timeout");

    // reset mid-run discards the breakpoint
    send_cmd(3'd6, 8'd0);
    wait_halted("mr_cpurst_timeout");
    send_cmd(3'd4, 8'h40);
    send_cmd(3'd1, 8'd0);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("mr_cpu_run", int'(cpu_run), 0);
    check("mr_cpu_reset", int'(cpu_reset), 1);
    check("mr_ready", int'(cmd_ready), 0);
    check("mr_count", int'(cycle_count), 0);
    check("mr_halted", int'(halted), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    wait_halted("mr_recover_timeout");
    send_cmd(3'd1, 8'd0);
    repeat (72) @(negedge clk);
    check("mr_bp_discarded", int'(halted), 0);
    check("mr_still_running", int'(cpu_run), 1);
    send_cmd(3'd2, 8'd0);
    @(negedge clk);
    check("mr_final_halt", int'(halted), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
